// File: rtl/serial_arith_pkg.sv
// Shared types and helpers for the bit-serial arithmetic cells.
package serial_arith_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int DEFAULT_WIDTH = 8;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/full_subtractor.sv
// Combinational 1-bit full subtractor: d = a - b - bin, with borrow-out.
module full_subtractor (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);

   assign d    = a ^ b ^ bin;
   assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (LSB first) behind a start/busy/done handshake.
// Build option SERIAL_SUBTRACTOR_SAT_EN: clamp diff to zero on unsigned underflow.
module serial_subtractor
   import serial_arith_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout
);

   localparam int               CNT_W = clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

   state_t           state;
   logic [WIDTH-1:0] shift_a;
   logic [WIDTH-1:0] shift_b;
   logic [WIDTH-1:0] result;
   logic [WIDTH-1:0] result_next;
   logic [CNT_W-1:0] cnt;
   logic             borrow;
   logic             cell_d;
   logic             cell_bout;

   full_subtractor u_cell (
      .a    (shift_a[0]),
      .b    (shift_b[0]),
      .bin  (borrow),
      .d    (cell_d),
      .bout (cell_bout)
   );

   // Each new difference bit enters at the MSB so the LSB lands in bit 0 after WIDTH shifts.
   assign result_next = {cell_d, result[WIDTH-1:1]};

`ifdef SERIAL_SUBTRACTOR_SAT_EN
   function automatic logic [WIDTH-1:0] sat_diff(input logic [WIDTH-1:0] raw,
                                                 input logic             uflow);
      return uflow ? '0 : raw;
   endfunction
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
         diff    <= '0;
         bout    <= 1'b0;
         shift_a <= '0;
         shift_b <= '0;
         result  <= '0;
         cnt     <= '0;
         borrow  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  shift_a <= a;
                  shift_b <= b;
                  borrow  <= bin;
                  cnt     <= '0;
                  busy    <= 1'b1;
                  state   <= RUN;
               end
            end
            RUN: begin
               shift_a <= {1'b0, shift_a[WIDTH-1:1]};
               shift_b <= {1'b0, shift_b[WIDTH-1:1]};
               borrow  <= cell_bout;
               result  <= result_next;
               cnt     <= cnt + CNT_W'(1);
               if (cnt == LAST) begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  bout  <= cell_bout;
`ifdef SERIAL_SUBTRACTOR_SAT_EN
                  diff  <= sat_diff(result_next, cell_bout);
`else
                  diff  <= result_next;
`endif
                  state <= DONE;
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH=8).
module tb_serial_subtractor;

   localparam int W = 8;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         bin;
   logic         busy;
   logic         done;
   logic [W-1:0] diff;
   logic         bout;

   int checks;
   int errors;
   logic [W-1:0] prev_diff;
   logic         prev_bout;

   localparam int NV = 5;
   logic [W-1:0] va   [NV] = '{8'd200, 8'd5,   8'd10, 8'd77, 8'd0};
   logic [W-1:0] vb   [NV] = '{8'd55,  8'd10,  8'd3,  8'd77, 8'd0};
   logic         vbin [NV] = '{1'b0,   1'b0,   1'b1,  1'b0,  1'b1};
`ifdef SERIAL_SUBTRACTOR_SAT_EN
   logic [W-1:0] ed   [NV] = '{8'd145, 8'd0,   8'd6,  8'd0,  8'd0};
`else
   logic [W-1:0] ed   [NV] = '{8'd145, 8'd251, 8'd6,  8'd0,  8'd255};
`endif
   logic         eb   [NV] = '{1'b0,   1'b1,   1'b0,  1'b0,  1'b1};

   serial_subtractor #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .bin   (bin),
      .busy  (busy),
      .done  (done),
      .diff  (diff),
      .bout  (bout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
      #12;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
      checks++; if (diff !== 8'd0) begin errors++; $display("FAIL reset_diff: got %0d expected 0", diff); end
      checks++; if (bout !== 1'b0) begin errors++; $display("FAIL reset_bout: got %b expected 0", bout); end
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      prev_diff = '0; prev_bout = 1'b0;
   endtask

   task automatic test_arith();
      for (int i = 0; i < NV; i++) begin
         start = 1'b1; a = va[i]; b = vb[i]; bin = vbin[i];
         @(posedge clk); #1;
         start = 1'b0; a = 8'hA5; b = 8'h3C; bin = ~vbin[i];
         checks++; if (busy !== 1'b1) begin errors++; $display("FAIL arith_busy_e0 vec %0d: got %b expected 1", i, busy); end
         for (int k = 1; k < W; k++) begin
            @(posedge clk); #1;
            checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL arith_run vec %0d cyc %0d: busy %b done %b expected 1 0", i, k, busy, done); end
            checks++; if (diff !== prev_diff || bout !== prev_bout) begin errors++; $display("FAIL arith_hold vec %0d cyc %0d: got %0d/%b expected %0d/%b", i, k, diff, bout, prev_diff, prev_bout); end
         end
         @(posedge clk); #1;
         checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL arith_done vec %0d: done %b busy %b expected 1 0", i, done, busy); end
         checks++; if (diff !== ed[i]) begin errors++; $display("FAIL arith_diff vec %0d: got %0d expected %0d", i, diff, ed[i]); end
         checks++; if (bout !== eb[i]) begin errors++; $display("FAIL arith_bout vec %0d: got %b expected %b", i, bout, eb[i]); end
         @(posedge clk); #1;
         checks++; if (done !== 1'b0 || diff !== ed[i]) begin errors++; $display("FAIL arith_after vec %0d: done %b diff %0d expected 0 %0d", i, done, diff, ed[i]); end
         prev_diff = ed[i]; prev_bout = eb[i];
      end
   endtask

   task automatic test_async_reset();
      start = 1'b1; a = 8'd200; b = 8'd55; bin = 1'b0;
      @(posedge clk); #1; start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL areset_ctrl: busy %b done %b expected 0 0", busy, done); end
      checks++; if (diff !== 8'd0 || bout !== 1'b0) begin errors++; $display("FAIL areset_data: diff %0d bout %b expected 0 0", diff, bout); end
      @(negedge clk); rst_n = 1'b1;
      for (int k = 0; k < W + 4; k++) begin
         @(posedge clk); #1;
         checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL areset_quiet cyc %0d: done %b busy %b expected 0 0", k, done, busy); end
      end
      start = 1'b1; a = 8'd1; b = 8'd1; bin = 1'b0;
      @(posedge clk); #1; start = 1'b0;
      for (int k = 1; k < W; k++) @(posedge clk);
      @(posedge clk); #1;
      checks++; if (done !== 1'b1 || diff !== 8'd0 || bout !== 1'b0) begin errors++; $display("FAIL areset_fresh: done %b diff %0d bout %b expected 1 0 0", done, diff, bout); end
      @(posedge clk); #1;
      prev_diff = 8'd0; prev_bout = 1'b0;
   endtask

   task automatic test_ignore_start();
      int ndone;
      ndone = 0;
      start = 1'b1; a = 8'd100; b = 8'd1; bin = 1'b0;
      @(posedge clk); #1; start = 1'b0;
      for (int k = 1; k < W; k++) begin
         @(posedge clk); #1;
         if (k == 3) begin start = 1'b1; a = 8'd7; b = 8'd7; end
         if (k == 4) start = 1'b0;
         if (done === 1'b1) ndone++;
      end
      @(posedge clk); #1;
      checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL ignore_done: done %b busy %b expected 1 0", done, busy); end
      checks++; if (diff !== 8'd99 || bout !== 1'b0) begin errors++; $display("FAIL ignore_diff: got %0d/%b expected 99/0", diff, bout); end
      for (int k = 0; k < W + 4; k++) begin
         @(posedge clk); #1;
         if (done === 1'b1 || busy === 1'b1) ndone++;
      end
      checks++; if (ndone !== 0) begin errors++; $display("FAIL ignore_extra: got %0d stray busy/done cycles expected 0", ndone); end
      prev_diff = 8'd99; prev_bout = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic exp_done;
      logic exp_busy;
      start = 1'b1; a = 8'd50; b = 8'd20; bin = 1'b0;
      for (int k = 0; k <= 30; k++) begin
         @(posedge clk); #1;
         exp_done = ((k % 10) == 8);
         exp_busy = ((k % 10) < 8);
         checks++; if (done !== exp_done || busy !== exp_busy) begin errors++; $display("FAIL b2b cyc %0d: done %b busy %b expected %b %b", k, done, busy, exp_done, exp_busy); end
         if (exp_done) begin
            checks++; if (diff !== 8'd30 || bout !== 1'b0) begin errors++; $display("FAIL b2b_diff cyc %0d: got %0d/%b expected 30/0", k, diff, bout); end
         end
      end
      start = 1'b0;
      for (int k = 0; k < W + 3; k++) @(posedge clk);
      #1;
      checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL b2b_drain: busy %b done %b expected 0 0", busy, done); end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_arith();
      test_async_reset();
      test_ignore_start();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
